// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi BER checker.
// Pure declarations; no clocked logic here.
package viterbi_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_t;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/viterbi_ber_checker_history.sv
// Reference-bit history shift register with an offset mux.
// bit_out is combinational from pre-shift state; the shift lands one cycle later.
module ber_history #(
  parameter int DEPTH = 32,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_out
);

  logic [DEPTH-1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[DEPTH-2:0], bit_in};
    end
  end

  assign bit_out = hist[sel];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Self-aligning BER checker: searches decoder latency, locks, counts bits/errors.
// All outputs registered, one cycle after the dec_valid_i edge; no backpressure.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int SYNC_LEN = 16,
  parameter int LOSS_LEN = 8,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ref_valid_i,
  input  logic                     ref_bit_i,
  input  logic                     dec_valid_i,
  input  logic                     dec_bit_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic [$clog2(DEPTH)-1:0] offset_o,
  output logic [CNT_W-1:0]         bit_cnt_o,
  output logic [CNT_W-1:0]         err_cnt_o,
  output logic                     err_pulse_o,
  output logic                     lock_lost_o,
  output logic                     search_wrap_o
);

  localparam int OFF_W  = $clog2(DEPTH);
  localparam int RUN_W  = $clog2(SYNC_LEN + 1);
  localparam int MISS_W = $clog2(LOSS_LEN + 1);

  ber_state_t        state, state_nxt;
  logic [OFF_W-1:0]  offset, offset_nxt, offset_inc;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [MISS_W-1:0] miss_cnt, miss_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_nxt, err_cnt, err_nxt;
  logic              pulse, pulse_nxt, lost, lost_nxt, wrap, wrap_nxt;
  logic              hist_bit, match, at_top;

  ber_history #(.DEPTH(DEPTH)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (ref_valid_i),
    .bit_in   (ref_bit_i),
    .sel      (offset),
    .bit_out  (hist_bit)
  );

  assign match      = (dec_bit_i == hist_bit);
  assign at_top     = (offset == OFF_W'(DEPTH - 1));
  assign offset_inc = at_top ? '0 : offset + OFF_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEARCH;
      offset   <= '0;
      run_cnt  <= '0;
      miss_cnt <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      pulse    <= 1'b0;
      lost     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      offset   <= offset_nxt;
      run_cnt  <= run_nxt;
      miss_cnt <= miss_nxt;
      bit_cnt  <= bit_nxt;
      err_cnt  <= err_nxt;
      pulse    <= pulse_nxt;
      lost     <= lost_nxt;
      wrap     <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run_cnt;
    miss_nxt   = miss_cnt;
    bit_nxt    = bit_cnt;
    err_nxt    = err_cnt;
    pulse_nxt  = 1'b0;
    lost_nxt   = lost;
    wrap_nxt   = wrap;

    if (dec_valid_i) begin
      case (state)
        SEARCH: begin
          if (match) begin
            if (run_cnt == RUN_W'(SYNC_LEN - 1)) begin
              // Locking bit itself is not counted.
              state_nxt = LOCKED;
              run_nxt   = '0;
              miss_nxt  = '0;
              bit_nxt   = '0;
              err_nxt   = '0;
            end else begin
              run_nxt = run_cnt + RUN_W'(1);
            end
          end else begin
            run_nxt    = '0;
            offset_nxt = offset_inc;
            if (at_top) wrap_nxt = 1'b1;
          end
        end
        LOCKED: begin
          bit_nxt = CNT_W'(sat_inc(64'(bit_cnt), CNT_W));
          if (match) begin
            miss_nxt = '0;
          end else begin
            err_nxt   = CNT_W'(sat_inc(64'(err_cnt), CNT_W));
            pulse_nxt = 1'b1;
            if (miss_cnt == MISS_W'(LOSS_LEN - 1)) begin
              // Counters hold so the last measurement stays readable.
              state_nxt  = SEARCH;
              lost_nxt   = 1'b1;
              run_nxt    = '0;
              miss_nxt   = '0;
              offset_nxt = offset_inc;
              if (at_top) wrap_nxt = 1'b1;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    // Clear wins over any same-cycle increment; FSM, offset and history are untouched.
    if (clear_i) begin
      bit_nxt   = '0;
      err_nxt   = '0;
      pulse_nxt = 1'b0;
      lost_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
    end
  end

  assign locked_o      = (state == LOCKED);
  assign offset_o      = offset;
  assign bit_cnt_o     = bit_cnt;
  assign err_cnt_o     = err_cnt;
  assign err_pulse_o   = pulse;
  assign lock_lost_o   = lost;
  assign search_wrap_o = wrap;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: PRBS7 reference, delayed decoded stream, err_pulse scoreboard.
// A second instance with 4-bit counters exercises saturation on the same stimulus.
module tb_viterbi_ber_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ref_valid, ref_bit, dec_valid, dec_bit, clear;

  logic        locked, pulse, lost, wrap;
  logic [4:0]  offset;
  logic [31:0] bit_cnt, err_cnt;

  logic        s_locked, s_pulse, s_lost, s_wrap;
  logic [4:0]  s_offset;
  logic [3:0]  s_bit_cnt, s_err_cnt;

  viterbi_ber_checker #(.DEPTH(32), .SYNC_LEN(16), .LOSS_LEN(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
    .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
    .locked_o(locked), .offset_o(offset), .bit_cnt_o(bit_cnt), .err_cnt_o(err_cnt),
    .err_pulse_o(pulse), .lock_lost_o(lost), .search_wrap_o(wrap)
  );

  viterbi_ber_checker #(.DEPTH(32), .SYNC_LEN(16), .LOSS_LEN(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
    .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
    .locked_o(s_locked), .offset_o(s_offset), .bit_cnt_o(s_bit_cnt), .err_cnt_o(s_err_cnt),
    .err_pulse_o(s_pulse), .lock_lost_o(s_lost), .search_wrap_o(s_wrap)
  );

  int checks = 0;
  int passed = 0;
  logic [6:0]  lfsr;
  logic [63:0] bh;   // bench copy of the reference history, bh[k] = ref bit k strobes ago
  bit exp_q[$];

  task automatic step(input logic rv, input logic rb, input logic dv, input logic db, input logic cl);
    ref_valid = rv; ref_bit = rb; dec_valid = dv; dec_bit = db; clear = cl;
    @(posedge clk); #1;
  endtask

  // One strobe of both streams; decoded bit is the reference from lat strobes back.
  task automatic drive(input int lat, input logic inv, input logic cl);
    logic rb, db;
    rb   = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], rb};
    db   = bh[lat] ^ inv;
    bh   = {bh[62:0], rb};
    step(1'b1, rb, 1'b1, db, cl);
  endtask

  task automatic do_reset();
    rst = 1'b0; ref_valid = 0; ref_bit = 0; dec_valid = 0; dec_bit = 0; clear = 0;
    lfsr = 7'h7F; bh = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic lock_at(input int lat, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      drive(lat, 1'b0, 1'b0);
      if (locked === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
    checks++; if (offset !== 5'd0) $display("FAIL reset_offset: got %0d want 0", offset); else passed++;
    checks++; if (bit_cnt !== 32'd0) $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); else passed++;
    checks++; if (err_cnt !== 32'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passed++;
    checks++; if (pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b want 0", pulse); else passed++;
    checks++; if (lost !== 1'b0) $display("FAIL reset_lock_lost: got %b want 0", lost); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL reset_search_wrap: got %b want 0", wrap); else passed++;
  endtask

  task automatic test_zero_latency();
    do_reset();
    repeat (15) drive(0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL zl_not_yet_locked: got %b want 0", locked); else passed++;
    drive(0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL zl_locked_16: got %b want 1", locked); else passed++;
    checks++; if (offset !== 5'd0) $display("FAIL zl_offset: got %0d want 0", offset); else passed++;
    checks++; if (bit_cnt !== 32'd0) $display("FAIL zl_bit_cnt_at_lock: got %0d want 0", bit_cnt); else passed++;
    repeat (100) drive(0, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 32'd100) $display("FAIL zl_bit_cnt: got %0d want 100", bit_cnt); else passed++;
    checks++; if (err_cnt !== 32'd0) $display("FAIL zl_err_cnt: got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_latency11();
    bit ok;
    do_reset();
    lock_at(11, 600, ok);
    checks++; if (ok !== 1'b1) $display("FAIL l11_lock_timeout: got %b want 1", ok); else passed++;
    checks++; if (offset !== 5'd11) $display("FAIL l11_offset: got %0d want 11", offset); else passed++;
    repeat (50) drive(11, 1'b0, 1'b0);
    checks++; if (err_cnt !== 32'd0) $display("FAIL l11_err_cnt: got %0d want 0", err_cnt); else passed++;
    checks++; if (bit_cnt !== 32'd50) $display("FAIL l11_bit_cnt: got %0d want 50", bit_cnt); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL l11_search_wrap: got %b want 0", wrap); else passed++;
  endtask

  task automatic test_sparse_errors();
    bit ok, inv, exp_p;
    int pulses;
    do_reset();
    lock_at(5, 600, ok);
    checks++; if (ok !== 1'b1) $display("FAIL se_lock_timeout: got %b want 1", ok); else passed++;
    checks++; if (offset !== 5'd5) $display("FAIL se_offset: got %0d want 5", offset); else passed++;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      inv = (i == 20 || i == 70 || i == 120 || i == 170);
      exp_q.push_back(inv);
      drive(5, inv, 1'b0);
      exp_p = exp_q.pop_front();
      checks++;
      if (pulse !== exp_p) $display("FAIL se_err_pulse[%0d]: got %b want %b", i, pulse, exp_p);
      else passed++;
      if (pulse === 1'b1) pulses++;
    end
    checks++; if (pulses != 4) $display("FAIL se_pulse_count: got %0d want 4", pulses); else passed++;
    checks++; if (err_cnt !== 32'd4) $display("FAIL se_err_cnt: got %0d want 4", err_cnt); else passed++;
    checks++; if (bit_cnt !== 32'd200) $display("FAIL se_bit_cnt: got %0d want 200", bit_cnt); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL se_locked: got %b want 1", locked); else passed++;
  endtask

  task automatic test_lock_loss();
    bit ok;
    do_reset();
    lock_at(5, 600, ok);
    checks++; if (ok !== 1'b1) $display("FAIL ll_lock_timeout: got %b want 1", ok); else passed++;
    repeat (7) drive(5, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL ll_still_locked_7: got %b want 1", locked); else passed++;
    drive(5, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL ll_unlocked: got %b want 0", locked); else passed++;
    checks++; if (lost !== 1'b1) $display("FAIL ll_lock_lost: got %b want 1", lost); else passed++;
    checks++; if (offset !== 5'd6) $display("FAIL ll_offset: got %0d want 6", offset); else passed++;
    checks++; if (err_cnt !== 32'd8) $display("FAIL ll_err_cnt: got %0d want 8", err_cnt); else passed++;
    repeat (3) drive(5, 1'b0, 1'b0);
    checks++; if (err_cnt !== 32'd8) $display("FAIL ll_err_held: got %0d want 8", err_cnt); else passed++;
    checks++; if (bit_cnt !== 32'd8) $display("FAIL ll_bit_held: got %0d want 8", bit_cnt); else passed++;
    lock_at(5, 2000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL ll_relock_timeout: got %b want 1", ok); else passed++;
    checks++; if (offset !== 5'd5) $display("FAIL ll_relock_offset: got %0d want 5", offset); else passed++;
    checks++; if (wrap !== 1'b1) $display("FAIL ll_relock_wrapped: got %b want 1", wrap); else passed++;
    checks++; if (lost !== 1'b1) $display("FAIL ll_lost_sticky: got %b want 1", lost); else passed++;
  endtask

  task automatic test_wrap_and_clear();
    bit ok, ever;
    do_reset();
    ever = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(40, 1'b0, 1'b0);
      if (locked === 1'b1) ever = 1'b1;
    end
    checks++; if (ever !== 1'b0) $display("FAIL wc_never_locked: got %b want 0", ever); else passed++;
    checks++; if (wrap !== 1'b1) $display("FAIL wc_search_wrap: got %b want 1", wrap); else passed++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (wrap !== 1'b0) $display("FAIL wc_wrap_cleared: got %b want 0", wrap); else passed++;

    do_reset();
    lock_at(5, 600, ok);
    checks++; if (ok !== 1'b1) $display("FAIL wc_lock_timeout: got %b want 1", ok); else passed++;
    repeat (10) drive(5, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 32'd10) $display("FAIL wc_bit_before_clear: got %0d want 10", bit_cnt); else passed++;
    drive(5, 1'b1, 1'b1);
    checks++; if (bit_cnt !== 32'd0) $display("FAIL wc_clear_bit: got %0d want 0", bit_cnt); else passed++;
    checks++; if (err_cnt !== 32'd0) $display("FAIL wc_clear_err: got %0d want 0", err_cnt); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL wc_clear_keeps_lock: got %b want 1", locked); else passed++;
    drive(5, 1'b0, 1'b0);
    checks++; if (bit_cnt !== 32'd1) $display("FAIL wc_after_clear_bit: got %0d want 1", bit_cnt); else passed++;
    checks++; if (err_cnt !== 32'd0) $display("FAIL wc_after_clear_err: got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_saturation_and_reset();
    bit ok;
    do_reset();
    lock_at(0, 600, ok);
    checks++; if (ok !== 1'b1) $display("FAIL sr_lock_timeout: got %b want 1", ok); else passed++;
    repeat (20) drive(0, 1'b0, 1'b0);
    checks++; if (s_bit_cnt !== 4'hF) $display("FAIL sr_saturated: got %0d want 15", s_bit_cnt); else passed++;
    checks++; if (bit_cnt !== 32'd20) $display("FAIL sr_wide_bit_cnt: got %0d want 20", bit_cnt); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) $display("FAIL sr_async_locked: got %b want 0", locked); else passed++;
    checks++; if (bit_cnt !== 32'd0) $display("FAIL sr_async_bit_cnt: got %0d want 0", bit_cnt); else passed++;
    checks++; if (offset !== 5'd0) $display("FAIL sr_async_offset: got %0d want 0", offset); else passed++;
    checks++; if (s_bit_cnt !== 4'd0) $display("FAIL sr_async_sat_cnt: got %0d want 0", s_bit_cnt); else passed++;
    @(posedge clk); #1;
    lfsr = 7'h7F; bh = '0; rst = 1'b1;
    repeat (15) drive(0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL sr_search_after_reset: got %b want 0", locked); else passed++;
    drive(0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL sr_relock_16: got %b want 1", locked); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_latency11();
    test_sparse_errors();
    test_lock_loss();
    test_wrap_and_clear();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
Downstream stage of the Viterbi encoder/channel/decoder chain. Records the raw transmit bit stream and the decoded bit stream, then finds the decoder's latency on its own by searching candidate bit offsets. Once locked to an offset, it counts decoded bits and bit errors. Gives bench and on-chip monitors a residual-BER measurement after channel error injection, without hand-tuning the decoder latency.

Parameters:
DEPTH, 32, history length in ref bits; max detectable decoder latency is DEPTH-1
SYNC_LEN, 16, consecutive matches required to declare lock
LOSS_LEN, 8, consecutive mismatches while locked that drop lock
CNT_W, 32, width of bit/error counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
ref_valid_i  input  1  ref_bit_i is valid (same strobe as the encoder enable)
ref_bit_i  input  1  transmit bit fed into the encoder
dec_valid_i  input  1  dec_bit_i is valid
dec_bit_i  input  1  decoder output bit
clear_i  input  1  synchronous clear of counters and sticky flags
locked_o  output  1  checker locked to an offset
offset_o  output  $clog2(DEPTH)  current candidate/locked offset
bit_cnt_o  output  CNT_W  decoded bits checked while locked
err_cnt_o  output  CNT_W  mismatches while locked
err_pulse_o  output  1  one-cycle pulse on each counted error
lock_lost_o  output  1  sticky: lock was lost at least once
search_wrap_o  output  1  sticky: offset search wrapped DEPTH-1 -> 0

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0, every register and output is 0: history, offset_o, run counters, bit_cnt_o, err_cnt_o, locked_o, err_pulse_o, lock_lost_o, search_wrap_o. FSM is in SEARCH. Reset asserted mid-operation aborts lock immediately with no other side effect.
- History: DEPTH-bit shift register. On ref_valid_i, ref_bit_i enters hist[0] and older bits move up one place. hist[k] is the ref bit k valid strobes ago.
- Compare: on dec_valid_i, match = (dec_bit_i == hist[offset_o]).
  - hist is sampled before the shift in the same cycle. When both valids are high, the compare uses the pre-shift history.
- FSM states: SEARCH, LOCKED. Only dec_valid_i cycles advance state. All outputs are registered, so the effect is visible 1 cycle after the dec_valid_i edge.
- SEARCH:
  - match: run_cnt+1.
  - mismatch: run_cnt=0 and offset_o+1. At DEPTH-1 the offset wraps to 0 and sets search_wrap_o.
  - When run_cnt reaches SYNC_LEN (the SYNC_LEN-th consecutive match): go to LOCKED, locked_o=1, bit_cnt_o=0, err_cnt_o=0, miss_cnt=0. The locking bit itself is not counted.
- LOCKED:
  - Each dec_valid_i: bit_cnt_o+1.
  - Mismatch: err_cnt_o+1, err_pulse_o=1 for one cycle, miss_cnt+1.
  - Match: miss_cnt=0.
  - When miss_cnt reaches LOSS_LEN: go to SEARCH, locked_o=0, lock_lost_o=1, run_cnt=0, offset_o+1 (with wrap).
  - bit_cnt_o and err_cnt_o hold their values after lock loss, so the last measurement stays readable.
- Counters saturate at all-ones and never wrap.
- clear_i: zeroes bit_cnt_o, err_cnt_o, lock_lost_o, search_wrap_o.
  - clear_i takes priority over an increment in the same cycle; that cycle's bit/error is dropped.
  - clear_i does not change FSM state, offset or history.
- dec_valid_i without ref_valid_i is legal. The offset meaning is defined in ref strobes only.

Decomposition:
- Package viterbi_pkg: typedef enum logic {SEARCH, LOCKED} ber_state_t; saturating-increment function sat_inc.
- One sub-module, ber_history: DEPTH-bit shift register plus offset mux. Ports: clk, rst, shift_en, bit_in, sel, bit_out.
- The FSM and the counters stay in viterbi_ber_checker.

Test Plan:
1. Zero latency: both valids every cycle, dec_bit = ref_bit from a PRBS7 stream, offset 0 → locked_o=1 after 16 dec strobes; offset_o=0; after 100 more strobes bit_cnt_o=100, err_cnt_o=0.
2. Latency 11: dec = ref delayed 11 strobes, PRBS7 stream → locked_o=1 with offset_o=11; err_cnt_o=0; search_wrap_o=0.
3. Sparse errors: locked at offset 5, invert 4 isolated dec bits within 200 strobes → err_cnt_o=4, exactly 4 err_pulse_o pulses, bit_cnt_o=200, locked_o stays 1.
4. Lock loss: locked, force 8 consecutive inverted dec bits → locked_o=0, lock_lost_o=1, offset_o=old+1; err_cnt_o=8 held; relock once aligned data resumes.
5. Wrap and clear: latency 40 (> DEPTH-1) → locked_o stays 0 and search_wrap_o=1. Then clear_i in the same cycle as an error while locked → counters read 0 and no increment.
6. Saturation and reset: CNT_W=4, locked, 20 error-free strobes → bit_cnt_o=15. Assert rst mid-stream → all outputs 0 asynchronously; FSM in SEARCH.
